// File: rtl/fb_pkg.sv
// Shared types, geometry constants and pixel helpers for the 128x64 mono framebuffer.
// The framebuffer is page-major: addr = page*128 + column.
package fb_pkg;

  localparam int COLS     = 128;
  localparam int PAGES    = 8;
  localparam int FB_AW    = 10;
  localparam int FB_XW    = 7;
  localparam int FB_YW    = 6;
  localparam int FB_DW    = 8;
  localparam int FB_DEPTH = COLS * PAGES;

  typedef enum logic [1:0] {
    OP_SET = 2'b00,
    OP_CLR = 2'b01,
    OP_TGL = 2'b10,
    OP_NOP = 2'b11
  } fb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_CLEAR = 2'b11
  } fb_state_e;

  function automatic logic [FB_AW-1:0] fb_addr(input logic [FB_XW-1:0] x,
                                               input logic [FB_YW-1:0] y);
    return {y[5:3], x};
  endfunction

  // Updated byte for one pixel: the row-within-page selects the bit.
  function automatic logic [FB_DW-1:0] fb_rmw(input fb_op_e op,
                                              input logic [FB_DW-1:0] d,
                                              input logic [2:0] bit_sel);
    logic [FB_DW-1:0] m;
    m = 8'h01 << bit_sel;
    case (op)
      OP_SET:  return d | m;
      OP_CLR:  return d & ~m;
      OP_TGL:  return d ^ m;
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: when both request, the one that did not win last time wins.
// last_grant resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       grant_valid,
  output logic       grant_id
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant_valid = |req;
    if (req == 2'b11) begin
      grant_id = ~last_q;
    end else begin
      grant_id = req[1];
    end
    last_d = last_q;
    if (grant_en && grant_valid) begin
      last_d = grant_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fb_pixel_arbiter.sv
// Framebuffer RAM owner: serialises pixel read-modify-write requests from two requesters
// and runs full-screen clear sweeps over the single RAM read/write port set.
module fb_pixel_arbiter
  import fb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [FB_XW-1:0] x0,
  input  logic [FB_YW-1:0] y0,
  output logic             done0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [FB_XW-1:0] x1,
  input  logic [FB_YW-1:0] y1,
  output logic             done1,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             busy,
  output logic [FB_AW-1:0] ram_rd_addr,
  input  logic [FB_DW-1:0] ram_rd_data,
  output logic [FB_AW-1:0] ram_wr_addr,
  output logic [FB_DW-1:0] ram_wr_data,
  output logic             ram_wr_en,
  output fb_state_e        dbg_state
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
  localparam logic [FB_AW-1:0] CLR_LAST = FB_AW'(FB_DEPTH - 1);

  // Handshake: a requester raises reqN with op/x/y stable and holds them until it sees
  // doneN high; on that same edge it drops reqN or presents its next request. doneN is a
  // one-cycle pulse coinciding with the RAM write that retires the request.

  fb_state_e        state_q, state_d;
  logic             id_q, id_d;
  fb_op_e           op_q, op_d;
  logic [2:0]       bit_q, bit_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [FB_AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [FB_AW-1:0] rd_addr_q, rd_addr_d;
  logic [FB_AW-1:0] wr_addr_q, wr_addr_d;
  logic [FB_DW-1:0] wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d;

  logic arb_en;
  logic grant_valid;
  logic grant_id;
  logic lat_done;

  // Grants are only taken in IDLE and only when no clear is asking for the RAM.
  assign arb_en   = (state_q == ST_IDLE) && !clr_req;
  assign lat_done = (lat_cnt_q == LAT_LAST);

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         ({req1, req0}),
    .grant_en    (arb_en),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
        end else if (grant_valid) begin
          state_d = ST_READ;
        end
      end
      ST_READ:  if (lat_done) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      ST_CLEAR: if (clr_cnt_q == CLR_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Write port values are computed one cycle ahead so the strobe lines up with WRITE/CLEAR.
  always_comb begin
    id_d      = id_q;
    op_d      = op_q;
    bit_d     = bit_q;
    lat_cnt_d = lat_cnt_q;
    clr_cnt_d = clr_cnt_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          clr_cnt_d = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = '0;
        end else if (grant_valid) begin
          id_d      = grant_id;
          op_d      = fb_op_e'(grant_id ? op1 : op0);
          bit_d     = grant_id ? y1[2:0] : y0[2:0];
          rd_addr_d = grant_id ? fb_addr(x1, y1) : fb_addr(x0, y0);
          lat_cnt_d = '0;
        end
      end
      ST_READ: begin
        if (lat_done) begin
          wr_en_d   = 1'b1;
          wr_addr_d = rd_addr_q;
          wr_data_d = fb_rmw(op_q, ram_rd_data, bit_q);
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q != CLR_LAST) begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = clr_cnt_q + 1'b1;
          wr_data_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q      <= 1'b0;
      op_q      <= OP_SET;
      bit_q     <= '0;
      lat_cnt_q <= '0;
      clr_cnt_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      id_q      <= id_d;
      op_q      <= op_d;
      bit_q     <= bit_d;
      lat_cnt_q <= lat_cnt_d;
      clr_cnt_q <= clr_cnt_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    clr_busy  = (state_q == ST_CLEAR);
    done0     = (state_q == ST_WRITE) && (id_q == 1'b0);
    done1     = (state_q == ST_WRITE) && (id_q == 1'b1);
    dbg_state = state_q;
  end

  assign ram_rd_addr = rd_addr_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram_wr_en   = wr_en_q;

endmodule

// File: tb/tb_fb_pixel_arbiter.sv
// Bench for fb_pixel_arbiter: behavioural RAM with RD_LAT read latency, write monitor,
// expected-write scoreboard and one task per scenario.
module tb_fb_pixel_arbiter;
  import fb_pkg::*;

  localparam int RD_LAT = 2;
  localparam int W      = 20;
  localparam logic [1:0] TAG_CLR = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0, req1, clr_req;
  logic [1:0] op0, op1;
  logic [6:0] x0, x1;
  logic [5:0] y0, y1;
  logic       done0, done1, clr_busy, busy, ram_wr_en;
  logic [9:0] ram_rd_addr, ram_wr_addr;
  logic [7:0] ram_rd_data, ram_wr_data;
  fb_state_e  dbg_state;

  always #5 clk = ~clk;

  fb_pixel_arbiter #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .x0(x0), .y0(y0), .done0(done0),
    .req1(req1), .op1(op1), .x1(x1), .y1(y1), .done1(done1),
    .clr_req(clr_req), .clr_busy(clr_busy), .busy(busy),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
    .dbg_state(dbg_state)
  );

  // RAM model: address registered by the DUT, one further stage here gives RD_LAT=2.
  logic [7:0] mem [0:1023];
  logic [7:0] rd_pipe;
  logic       pre_en = 1'b0;
  logic [9:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  always @(posedge clk) begin
    rd_pipe <= mem[ram_rd_addr];
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    else if (pre_en) mem[pre_addr] <= pre_data;
  end
  assign ram_rd_data = rd_pipe;

  // Write monitor: records {tag, addr, data}; tag = done id, 2 for clear, 3 for anything odd.
  logic [W-1:0] obs_mem [0:2047];
  int   obs_wr = 0;
  int   orphan_cnt = 0;
  logic mon_en = 1'b1;

  function automatic logic [1:0] wr_tag(input logic d0, input logic d1, input logic cb);
    if (d0 && !d1 && !cb) return 2'd0;
    if (d1 && !d0 && !cb) return 2'd1;
    if (cb && !d0 && !d1) return 2'd2;
    return 2'd3;
  endfunction

  always @(negedge clk) begin
    if (mon_en && ram_wr_en && obs_wr < 2048) begin
      obs_mem[obs_wr] <= {wr_tag(done0, done1, clr_busy), ram_wr_addr, ram_wr_data};
      obs_wr <= obs_wr + 1;
    end
    if ((done0 || done1) && !ram_wr_en) orphan_cnt <= orphan_cnt + 1;
  end

  logic [W-1:0] exp_q [$];
  logic [7:0]   shadow [0:1023];
  int           obs_rd = 0;
  int           checks = 0;
  int           failures = 0;

  function automatic logic [7:0] px_model(input logic [1:0] op, input logic [7:0] d,
                                          input logic [2:0] b);
    logic [7:0] m;
    m = 8'h01 << b;
    if (op == 2'b00) return d | m;
    if (op == 2'b01) return d & ~m;
    if (op == 2'b10) return d ^ m;
    return d;
  endfunction

  task automatic push_px(input int id, input logic [1:0] op, input logic [6:0] x,
                         input logic [5:0] y);
    logic [9:0] a;
    a = {y[5:3], x};
    shadow[a] = px_model(op, shadow[a], y[2:0]);
    exp_q.push_back({2'(id), a, shadow[a]});
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en    = 1'b0;
    shadow[a] = d;
  endtask

  task automatic drive_px(input int id, input logic [1:0] op, input logic [6:0] x,
                          input logic [5:0] y, output int lat);
    int t_g;
    bit ok;
    t_g = -1;
    ok  = 1'b0;
    lat = 0;
    if (id == 0) begin op0 = op; x0 = x; y0 = y; req0 = 1'b1; end
    else         begin op1 = op; x1 = x; y1 = y; req1 = 1'b1; end
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (t_g < 0 && busy && !clr_busy) t_g = i;
      if ((id == 0 && done0) || (id == 1 && done1)) begin
        ok  = 1'b1;
        lat = i - t_g + 1;
        break;
      end
    end
    if (id == 0) req0 = 1'b0;
    else         req1 = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL done%0d timeout: got no done, expected one within 1500 cycles", id);
    end
  endtask

  task automatic test_reset();
    int n_wr;
    checks++;
    if ({busy, clr_busy, done0, done1, ram_wr_en} !== 5'b0) begin
      failures++;
      $display("FAIL por_flags: got %b expected 00000", {busy, clr_busy, done0, done1, ram_wr_en});
    end
    checks++;
    if ({ram_rd_addr, ram_wr_addr, ram_wr_data} !== 28'h0) begin
      failures++;
      $display("FAIL por_buses: got %h expected 0", {ram_rd_addr, ram_wr_addr, ram_wr_data});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL por_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b0;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (clr_busy !== 1'b1) begin
      failures++;
      $display("FAIL clear_started: got clr_busy=%b expected 1", clr_busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, clr_busy, done0, done1, ram_wr_en} !== 5'b0) begin
      failures++;
      $display("FAIL mid_clear_flags: got %b expected 00000", {busy, clr_busy, done0, done1, ram_wr_en});
    end
    checks++;
    if ({ram_rd_addr, ram_wr_addr, ram_wr_data} !== 28'h0) begin
      failures++;
      $display("FAIL mid_clear_buses: got %h expected 0", {ram_rd_addr, ram_wr_addr, ram_wr_data});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL mid_clear_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst  = 1'b0;
    n_wr = 0;
    repeat (10) begin
      @(negedge clk);
      if (ram_wr_en || busy) n_wr++;
    end
    checks++;
    if (n_wr != 0) begin
      failures++;
      $display("FAIL mid_clear_after: got %0d active cycles expected 0", n_wr);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_clear_priority();
    int n;
    int lat;
    logic [W-1:0] exp_w;
    for (int i = 0; i < 1024; i++) begin
      exp_q.push_back({TAG_CLR, 10'(i), 8'h00});
      shadow[i] = 8'h00;
    end
    push_px(0, 2'b00, 7'h10, 6'h1B);
    @(negedge clk);
    clr_req = 1'b1;
    n = 0;
    fork
      drive_px(0, 2'b00, 7'h10, 6'h1B, lat);
      begin
        @(negedge clk);
        clr_req = 1'b0;
        for (int i = 0; i < 1100; i++) begin
          if (clr_busy) n++;
          else if (n > 0) break;
          @(negedge clk);
        end
      end
    join
    checks++;
    if (n != 1024) begin
      failures++;
      $display("FAIL clr_busy_len: got %0d expected 1024", n);
    end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr) begin
        failures++;
        $display("FAIL clear_prio write: got none expected %h", exp_w);
      end else begin
        if (obs_mem[obs_rd] !== exp_w) begin
          failures++;
          $display("FAIL clear_prio write: got %h expected %h", obs_mem[obs_rd], exp_w);
        end
        obs_rd++;
      end
    end
    checks++;
    if (obs_wr != obs_rd) begin
      failures++;
      $display("FAIL clear_prio extra: got %0d writes expected 0", obs_wr - obs_rd);
      obs_rd = obs_wr;
    end
  endtask

  task automatic test_set_pixel();
    int lat;
    logic [W-1:0] exp_w;
    preload(10'h2A5, 8'h00);
    exp_q.push_back({2'd0, 10'h2A5, 8'h04});
    shadow[10'h2A5] = 8'h04;
    drive_px(0, 2'b00, 7'h25, 6'h2A, lat);
    checks++;
    if (lat != RD_LAT + 1) begin
      failures++;
      $display("FAIL set_latency: got %0d expected %0d", lat, RD_LAT + 1);
    end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr) begin
        failures++;
        $display("FAIL set_pixel write: got none expected %h", exp_w);
      end else begin
        if (obs_mem[obs_rd] !== exp_w) begin
          failures++;
          $display("FAIL set_pixel write: got %h expected %h", obs_mem[obs_rd], exp_w);
        end
        obs_rd++;
      end
    end
    checks++;
    if (obs_wr != obs_rd) begin
      failures++;
      $display("FAIL set_pixel extra: got %0d writes expected 0", obs_wr - obs_rd);
      obs_rd = obs_wr;
    end
  endtask

  task automatic test_toggle_clear();
    int lat;
    logic [W-1:0] exp_w;
    preload(10'h07F, 8'hFF);
    exp_q.push_back({2'd1, 10'h07F, 8'h7F});
    exp_q.push_back({2'd1, 10'h07F, 8'hFF});
    exp_q.push_back({2'd0, 10'h2A5, 8'h04});
    shadow[10'h07F] = 8'hFF;
    drive_px(1, 2'b01, 7'd127, 6'd7, lat);
    drive_px(1, 2'b10, 7'd127, 6'd7, lat);
    drive_px(0, 2'b11, 7'h25, 6'h2A, lat);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr) begin
        failures++;
        $display("FAIL toggle_clear write: got none expected %h", exp_w);
      end else begin
        if (obs_mem[obs_rd] !== exp_w) begin
          failures++;
          $display("FAIL toggle_clear write: got %h expected %h", obs_mem[obs_rd], exp_w);
        end
        obs_rd++;
      end
    end
    checks++;
    if (obs_wr != obs_rd) begin
      failures++;
      $display("FAIL toggle_clear extra: got %0d writes expected 0", obs_wr - obs_rd);
      obs_rd = obs_wr;
    end
  endtask

  task automatic test_contention();
    logic [1:0] a_op [4];
    logic [1:0] b_op [4];
    logic [5:0] a_y  [4];
    logic [5:0] b_y  [4];
    logic [W-1:0] exp_w;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    // last_grant is back at its reset value, so requester 0 takes the first tie.
    for (int k = 0; k < 4; k++) begin
      a_op[k] = 2'($urandom_range(0, 3));
      b_op[k] = 2'($urandom_range(0, 3));
      a_y[k]  = 6'($urandom_range(0, 63));
      b_y[k]  = 6'($urandom_range(0, 63));
      push_px(0, a_op[k], 7'(1 + 5 * k), a_y[k]);
      push_px(1, b_op[k], 7'(64 + k), b_y[k]);
    end
    fork
      begin
        int lat_a;
        for (int k = 0; k < 4; k++) drive_px(0, a_op[k], 7'(1 + 5 * k), a_y[k], lat_a);
      end
      begin
        int lat_b;
        for (int k = 0; k < 4; k++) drive_px(1, b_op[k], 7'(64 + k), b_y[k], lat_b);
      end
    join
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr) begin
        failures++;
        $display("FAIL contention write: got none expected %h", exp_w);
      end else begin
        if (obs_mem[obs_rd] !== exp_w) begin
          failures++;
          $display("FAIL contention write: got %h expected %h", obs_mem[obs_rd], exp_w);
        end
        obs_rd++;
      end
    end
    checks++;
    if (obs_wr != obs_rd) begin
      failures++;
      $display("FAIL contention extra: got %0d writes expected 0", obs_wr - obs_rd);
      obs_rd = obs_wr;
    end
  endtask

  task automatic test_reset_mid_rmw();
    int lat;
    int n_act;
    bit seen;
    logic [W-1:0] exp_w;
    @(negedge clk);
    op0 = 2'b00; x0 = 7'h11; y0 = 6'h09; req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dbg_state == ST_READ) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rmw_grant: got state %0d expected %0d", dbg_state, ST_READ);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done0, done1, ram_wr_en} !== 4'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL mid_rmw_reset: got flags %b state %0d expected 0000 state 0",
               {busy, done0, done1, ram_wr_en}, dbg_state);
    end
    req0 = 1'b0;
    @(negedge clk);
    rst   = 1'b0;
    n_act = 0;
    repeat (10) begin
      @(negedge clk);
      if (ram_wr_en || done0 || done1) n_act++;
    end
    checks++;
    if (n_act != 0) begin
      failures++;
      $display("FAIL mid_rmw_after: got %0d write/done cycles expected 0", n_act);
    end
    preload(10'h3C5, 8'hA5);
    exp_q.push_back({2'd1, 10'h3C5, 8'hB5});
    shadow[10'h3C5] = 8'hB5;
    drive_px(1, 2'b10, 7'h45, 6'h3C, lat);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_wr) begin
        failures++;
        $display("FAIL after_reset write: got none expected %h", exp_w);
      end else begin
        if (obs_mem[obs_rd] !== exp_w) begin
          failures++;
          $display("FAIL after_reset write: got %h expected %h", obs_mem[obs_rd], exp_w);
        end
        obs_rd++;
      end
    end
    checks++;
    if (obs_wr != obs_rd) begin
      failures++;
      $display("FAIL after_reset extra: got %0d writes expected 0", obs_wr - obs_rd);
      obs_rd = obs_wr;
    end
  endtask

  initial begin
    req0 = 1'b0; req1 = 1'b0; clr_req = 1'b0;
    op0 = '0; op1 = '0; x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_clear_priority();
    test_set_pixel();
    test_toggle_clear();
    test_contention();
    test_reset_mid_rmw();
    repeat (2) @(negedge clk);
    checks++;
    if (orphan_cnt != 0) begin
      failures++;
      $display("FAIL orphan_done: got %0d done pulses without a write expected 0", orphan_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
